// File: rtl/tensor_core_operand_loader_if.sv
// Command/element valid-ready bundle for the tensor core operand loader.
// master drives valid/op/data; slave (the loader) drives the two readies.
interface tensor_core_operand_loader_if #(
  parameter int BUS_WIDTH = 7
);
  logic               cmd_valid_in;
  logic [2:0]         cmd_op_in;
  logic               cmd_ready_out;
  logic               elem_valid_in;
  logic [BUS_WIDTH:0] elem_data_in;
  logic               elem_ready_out;

  modport master (
    output cmd_valid_in,
    output cmd_op_in,
    output elem_valid_in,
    output elem_data_in,
    input  cmd_ready_out,
    input  elem_ready_out
  );

  modport slave (
    input  cmd_valid_in,
    input  cmd_op_in,
    input  elem_valid_in,
    input  elem_data_in,
    output cmd_ready_out,
    output elem_ready_out
  );
endinterface

// File: rtl/tensor_core_operand_loader.sv
// Operand loader: takes an op, streams 9/18 elements into two 3x3 matrices,
// pulses start, waits COMPUTE_CYCLES, pulses done; error pulse on bad op.
module tensor_core_operand_loader #(
  parameter int BUS_WIDTH      = 7,
  parameter int COMPUTE_CYCLES = 9
) (
  input  logic clock_in,
  input  logic reset_n_in,
  tensor_core_operand_loader_if.slave bus,
  output logic should_start_tensor_core,
  output logic [2:0] matrix_operation_select,
  output logic [2:0][2:0][BUS_WIDTH:0] tensor_core_input1,
  output logic [2:0][2:0][BUS_WIDTH:0] tensor_core_input2,
  output logic busy_out,
  output logic done_out,
  output logic error_out
);

  localparam int CW = $clog2(COMPUTE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  typedef logic [BUS_WIDTH:0] elem_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  elem_t       m1_q [9];
  elem_t       m1_d [9];
  elem_t       m2_q [9];
  elem_t       m2_d [9];

  logic [4:0]  last_idx;
  logic [3:0]  idx2;

  // ReLU only fills input1, so its stream ends after 9 elements.
  assign last_idx = (op_q == 3'b010) ? 5'd8 : 5'd17;
  // idx 9..17 -> 0..8; mod-16 wrap makes this exact for 16 and 17.
  assign idx2     = idx_q[3:0] - 4'd9;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    m1_d    = m1_q;
    m2_d    = m2_q;
    bus.cmd_ready_out        = 1'b0;
    bus.elem_ready_out       = 1'b0;
    should_start_tensor_core = 1'b0;
    done_out = 1'b0;
    busy_out = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy_out          = 1'b0;
        bus.cmd_ready_out = 1'b1;
        if (bus.cmd_valid_in) begin
          if (bus.cmd_op_in <= 3'b010) begin
            op_d    = bus.cmd_op_in;
            idx_d   = 5'd0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        bus.elem_ready_out = 1'b1;
        if (bus.elem_valid_in) begin
          if (idx_q < 5'd9) begin
            m1_d[idx_q[3:0]] = bus.elem_data_in;
          end else begin
            m2_d[idx2] = bus.elem_data_in;
          end
          idx_d = idx_q + 5'd1;
          if (idx_q == last_idx) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        should_start_tensor_core = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CW'(COMPUTE_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      m1_q    <= '{default: '0};
      m2_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
    end
  end

  assign error_out               = err_q;
  assign matrix_operation_select = op_q;

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign tensor_core_input1[r][c] = m1_q[3*r+c];
      assign tensor_core_input2[r][c] = m2_q[3*r+c];
    end
  end

endmodule

// File: tb/tb_tensor_core_operand_loader.sv
// Directed self-checking bench for tensor_core_operand_loader.
// Loads, stalls, bad op, back-pressure and mid-WAIT reset.
module tb_tensor_core_operand_loader;

  localparam int BW = 7;
  localparam int CC = 9;

  logic clock_in = 1'b0;
  logic reset_n_in = 1'b0;
  always #5 clock_in = ~clock_in;

  tensor_core_operand_loader_if #(.BUS_WIDTH(BW)) bus();

  logic start;
  logic [2:0] sel;
  logic [2:0][2:0][BW:0] in1;
  logic [2:0][2:0][BW:0] in2;
  logic busy;
  logic done;
  logic err;

  tensor_core_operand_loader #(
    .BUS_WIDTH(BW),
    .COMPUTE_CYCLES(CC)
  ) dut (
    .clock_in(clock_in),
    .reset_n_in(reset_n_in),
    .bus(bus),
    .should_start_tensor_core(start),
    .matrix_operation_select(sel),
    .tensor_core_input1(in1),
    .tensor_core_input2(in2),
    .busy_out(busy),
    .done_out(done),
    .error_out(err)
  );

  int checks = 0;
  int errors = 0;
  int vals[18];
  int exp1[9];
  int exp2[9];

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag,
                          input logic cr, input logic er,
                          input logic st, input logic bz,
                          input logic dn, input logic ee);
    chk({tag, ".cmd_ready"}, bus.cmd_ready_out, cr);
    chk({tag, ".elem_ready"}, bus.elem_ready_out, er);
    chk({tag, ".start"}, start, st);
    chk({tag, ".busy"}, busy, bz);
    chk({tag, ".done"}, done, dn);
    chk({tag, ".error"}, err, ee);
  endtask

  task automatic chk_mats(input string tag);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s.in1[%0d]", tag, i),
          $signed(in1[i/3][i%3]), exp1[i]);
      chk($sformatf("%s.in2[%0d]", tag, i),
          $signed(in2[i/3][i%3]), exp2[i]);
    end
  endtask

  task automatic issue(input logic [2:0] op, input bit keep);
    bus.cmd_valid_in = 1'b1;
    bus.cmd_op_in = op;
    chk("issue.ready", bus.cmd_ready_out, 1'b1);
    tick();
    if (!keep) bus.cmd_valid_in = 1'b0;
    chk("load.busy", busy, 1'b1);
    chk("load.elem_ready", bus.elem_ready_out, 1'b1);
    chk("load.cmd_ready", bus.cmd_ready_out, 1'b0);
  endtask

  task automatic feed(input int n, input bit stall);
    for (int k = 0; k < n; k++) begin
      if (stall) begin
        bus.elem_valid_in = 1'b0;
        tick();
        chk("stall.elem_ready", bus.elem_ready_out, 1'b1);
        chk("stall.start", start, 1'b0);
      end
      bus.elem_valid_in = 1'b1;
      bus.elem_data_in = vals[k][BW:0];
      tick();
    end
    bus.elem_valid_in = 1'b0;
  endtask

  // Entered in the START cycle; leaves in the IDLE cycle after DONE.
  task automatic run_wait(input string tag);
    chk_ctrl({tag, ".start"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= CC + 1; i++) begin
      tick();
      chk($sformatf("%s.done@%0d", tag, i), done, (i == CC + 1));
      chk($sformatf("%s.start@%0d", tag, i), start, 1'b0);
      chk($sformatf("%s.cmd_ready@%0d", tag, i),
          bus.cmd_ready_out, 1'b0);
    end
    tick();
    chk_ctrl({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.cmd_valid_in = 1'b0;
    bus.cmd_op_in = 3'b000;
    bus.elem_valid_in = 1'b0;
    bus.elem_data_in = '0;

    // reset
    tick();
    tick();
    chk_ctrl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.sel", sel, 3'd0);
    for (int i = 0; i < 9; i++) begin
      exp1[i] = 0;
      exp2[i] = 0;
    end
    chk_mats("reset");
    reset_n_in = 1'b1;
    tick();

    // multiply, elements 1..18
    for (int k = 0; k < 18; k++) vals[k] = k + 1;
    issue(3'b000, 1'b0);
    chk("mul.sel", sel, 3'd0);
    feed(18, 1'b0);
    for (int i = 0; i < 9; i++) begin
      exp1[i] = i + 1;
      exp2[i] = i + 10;
    end
    chk_mats("mul");
    run_wait("mul");
    chk_mats("mul.held");

    // add with all 5s, preloads input2 for ReLU
    for (int k = 0; k < 18; k++) vals[k] = 5;
    issue(3'b001, 1'b0);
    feed(18, 1'b0);
    chk("add.sel", sel, 3'd1);
    run_wait("add");

    // ReLU, -3..5, input2 untouched
    for (int k = 0; k < 9; k++) vals[k] = k - 3;
    issue(3'b010, 1'b0);
    feed(9, 1'b0);
    chk("relu.sel", sel, 3'd2);
    for (int i = 0; i < 9; i++) begin
      exp1[i] = i - 3;
      exp2[i] = 5;
    end
    chk_mats("relu");
    run_wait("relu");

    // illegal op 101
    bus.cmd_valid_in = 1'b1;
    bus.cmd_op_in = 3'b101;
    tick();
    bus.cmd_valid_in = 1'b0;
    chk_ctrl("illegal", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("illegal.sel", sel, 3'd2);
    chk_mats("illegal");
    tick();
    chk_ctrl("illegal.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // add with stalls; a multiply command is held pending throughout
    for (int k = 0; k < 18; k++) vals[k] = k + 1;
    issue(3'b001, 1'b1);
    bus.cmd_op_in = 3'b000;
    feed(18, 1'b1);
    chk("stall.sel", sel, 3'd1);
    chk("stall.cmd_ready", bus.cmd_ready_out, 1'b0);
    for (int i = 0; i < 9; i++) begin
      exp1[i] = i + 1;
      exp2[i] = i + 10;
    end
    chk_mats("stall");
    run_wait("bp");
    tick();
    bus.cmd_valid_in = 1'b0;
    chk("bp.busy", busy, 1'b1);
    chk("bp.sel", sel, 3'd0);
    chk("bp.elem_ready", bus.elem_ready_out, 1'b1);

    // extreme values, then reset in WAIT cycle 4
    for (int k = 0; k < 18; k++) vals[k] = (k % 2) ? 127 : -128;
    feed(18, 1'b0);
    for (int i = 0; i < 9; i++) begin
      exp1[i] = (i % 2) ? 127 : -128;
      exp2[i] = ((i + 9) % 2) ? 127 : -128;
    end
    chk_mats("edge");
    chk("edge.start", start, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("wait%0d.busy", i), busy, 1'b1);
      chk($sformatf("wait%0d.done", i), done, 1'b0);
    end
    reset_n_in = 1'b0;
    tick();
    chk_ctrl("midreset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midreset.sel", sel, 3'd0);
    for (int i = 0; i < 9; i++) begin
      exp1[i] = 0;
      exp2[i] = 0;
    end
    chk_mats("midreset");
    reset_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("post.done@%0d", i), done, 1'b0);
      chk($sformatf("post.start@%0d", i), start, 1'b0);
      chk($sformatf("post.busy@%0d", i), busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tensor_core_operand_loader.md
TENSOR_CORE_OPERAND_LOADER -- requirements
Module: tensor_core_operand_loader

Interface
REQ-001 Parameter: BUS_WIDTH, default 7, element width is BUS_WIDTH+1 bits, two's complement.
REQ-002 Parameter: COMPUTE_CYCLES, default 9, number of cycles the downstream tensor core needs after its start cycle.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clock_in  input  1  rising-edge clock.
REQ-005 reset_n_in  input  1  synchronous, active-low reset.
REQ-006 cmd_valid_in  input  1  a command is offered.
REQ-007 cmd_op_in  input  3  operation: 000 multiply, 001 add, 010 ReLU.
REQ-008 cmd_ready_out  output  1  a command is accepted when both valid and ready are high.
REQ-009 elem_valid_in  input  1  an operand element is offered.
REQ-010 elem_data_in  input  BUS_WIDTH+1  signed operand element.
REQ-011 elem_ready_out  output  1  an element is accepted when both valid and ready are high.
REQ-012 should_start_tensor_core  output  1  one-cycle start pulse to the tensor core.
REQ-013 matrix_operation_select  output  3  latched operation, driven to the tensor core.
REQ-014 tensor_core_input1, tensor_core_input2  output  [3][3] x (BUS_WIDTH+1)  operand matrices, signed.
REQ-015 busy_out  output  1  high in every state except IDLE.
REQ-016 done_out  output  1  one-cycle pulse: tensor core outputs are complete and valid.
REQ-017 error_out  output  1  one-cycle pulse on an illegal op.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, START, WAIT, DONE.
REQ-019 IDLE: cmd_ready_out=1, elem_ready_out=0.
- Accepted op in {000,001,010}: latch op into matrix_operation_select, clear element index to 0, go to LOAD.
- Accepted op in {011..111}: error_out=1 the next cycle; stay IDLE; matrices and select unchanged.
REQ-020 LOAD: elem_ready_out=1, cmd_ready_out=0.
- Each accepted element k goes to input1[k/3][k%3] for k<9, else input2[(k-9)/3][(k-9)%3]; then k increments.
- Cycles with elem_valid_in=0 are stalls: no state change.
REQ-021 Element count SHALL be 18 for ops 000/001 and 9 for op 010; input2 is not written for ReLU and keeps its previous value.
REQ-022 The handshake of the last element SHALL move LOAD to START on the same edge; the last element lands in its register at that edge.
REQ-023 START SHALL last exactly one cycle with should_start_tensor_core=1 and both ready outputs low; it then goes to WAIT.
REQ-024 WAIT SHALL last exactly COMPUTE_CYCLES cycles, tracked by a wait counter, then go to DONE.
- If start is asserted in cycle S, done_out=1 in cycle S+COMPUTE_CYCLES+1.
REQ-025 DONE SHALL last one cycle with done_out=1, then go to IDLE.
- A command offered during DONE is not accepted (cmd_ready_out=0).
REQ-026 Both matrices and matrix_operation_select SHALL hold constant from START through DONE and in the following IDLE, until the next accepted element.
REQ-027 should_start_tensor_core SHALL never be high outside START; done_out never outside DONE; error_out only in the cycle after an illegal op.
REQ-028 Elements are stored unmodified: no arithmetic, no saturation, no sign change.

Reset
REQ-029 With reset_n_in=0 at a rising edge, the block SHALL go to IDLE and clear all 18 matrix elements, matrix_operation_select, the element index and the wait counter to 0.
REQ-030 During reset, should_start_tensor_core, done_out, error_out, busy_out and elem_ready_out SHALL read 0 and cmd_ready_out SHALL read 1 from the cycle after the reset edge.
REQ-031 Reset in any state, including mid-LOAD or mid-WAIT, SHALL abort the operation with no start or done pulse afterwards.

Verification
REQ-032 Multiply load: cmd op=000, then elements 1..18 with no stalls -> input1 = [[1,2,3],[4,5,6],[7,8,9]], input2 = [[10..18]] row-major; start pulse one cycle after element 18; done_out exactly 10 cycles after the start pulse.
REQ-033 ReLU load: preload input2 with 5s via an add op, then cmd op=010 and nine elements -3..5 -> input1 = -3..5 row-major, input2 still all 5s, start after the 9th element.
REQ-034 Stalls: op=001 with elem_valid_in low every other cycle -> values are identical to a no-stall run; the start pulse comes one cycle after the 18th handshake.
REQ-035 Illegal op: cmd op=101 -> error_out=1 for one cycle, busy_out stays 0, and a following legal command is accepted.
REQ-036 Mid-operation reset: reset_n_in=0 during WAIT cycle 4 -> the next cycle reads IDLE with all outputs at reset values; no done_out pulse ever appears.
REQ-037 Back-pressure: cmd_valid_in held high during LOAD, START, WAIT and DONE -> cmd_ready_out=0 in those states, and the command is accepted in the first IDLE cycle after DONE.
